mac_array_pipe: RTL and testbench

Multi-lane, pipelined multiply-accumulate engine. It is the parametrised successor to the single-lane 8x8/24-bit MAC, with these additions:
- configurable lane count and operand/accumulator widths;
- signed or unsigned arithmetic;
- saturating accumulation with sticky overflow flags;
- an automatic accumulation window that dumps a result after `len` samples.

It sits between the operand fetch logic and the result collection logic.

---
 rtl/mac_array_pipe.sv | 133 +++++++++++++
 tb/tb_mac_array_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_pipe.sv
// Multi-lane two-stage multiply-accumulate engine with saturating accumulation,
// sticky per-lane overflow flags and an automatic len-sample dump window.
module mac_array_pipe #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [LANES*DATA_W-1:0]  a,
  input  logic [LANES*DATA_W-1:0]  b,
  input  logic [CNT_W-1:0]         len,
  output logic [LANES*ACC_W-1:0]   acc_out,
  output logic                     acc_valid,
  output logic [LANES-1:0]         sat,
  output logic                     busy
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned EXT_W  = ACC_W + 1 - PROD_W;
  localparam logic        SGN    = (SIGNED != 0);
  localparam logic [ACC_W-1:0] U_MAX = '1;
  localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                 p_valid;
  logic [PROD_W-1:0]    prod_q  [LANES];
  logic [ACC_W-1:0]     acc_q   [LANES];
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     len_q;
  logic [LANES-1:0]     sat_run;

  logic [PROD_W-1:0]    mul_c   [LANES];
  logic [ACC_W-1:0]     clamp_c [LANES];
  logic                 ovf_c   [LANES];
  logic [CNT_W-1:0]     eff_len;
  logic                 free_run;
  logic                 win_last;

  // Per-lane multiply and saturating add; operands are widened to the product
  // width first so the truncated product is exact for both signednesses.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DATA_W-1:0] a_l, b_l;
    logic [PROD_W-1:0] a_x, b_x;
    logic [ACC_W:0]    p_x, acc_x, sum;

    assign a_l = a[g*DATA_W +: DATA_W];
    assign b_l = b[g*DATA_W +: DATA_W];
    assign a_x = {{DATA_W{SGN & a_l[DATA_W-1]}}, a_l};
    assign b_x = {{DATA_W{SGN & b_l[DATA_W-1]}}, b_l};
    assign mul_c[g] = a_x * b_x;

    assign p_x   = {{EXT_W{SGN & prod_q[g][PROD_W-1]}}, prod_q[g]};
    assign acc_x = {SGN & acc_q[g][ACC_W-1], acc_q[g]};
    assign sum   = acc_x + p_x;

    assign ovf_c[g]   = SGN ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
    assign clamp_c[g] = !ovf_c[g] ? sum[ACC_W-1:0] :
                        !SGN      ? U_MAX :
                        sum[ACC_W] ? S_MIN : S_MAX;
  end

  // The first sample of a window sees len directly; later samples use the latch.
  assign eff_len  = (cnt_q == '0) ? len : len_q;
  assign free_run = (eff_len == '0);
  assign win_last = !free_run && (cnt_q == eff_len - CNT_W'(1));
  assign busy     = p_valid | (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid   <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      sat_run   <= '0;
      acc_out   <= '0;
      sat       <= '0;
      acc_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else if (clr) begin
      p_valid   <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      sat_run   <= '0;
      acc_out   <= '0;
      sat       <= '0;
      acc_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      acc_valid <= 1'b0;
      p_valid   <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < LANES; i++) prod_q[i] <= mul_c[i];
      end
      if (p_valid) begin
        if (cnt_q == '0) len_q <= len;
        if (free_run) begin
          for (int i = 0; i < LANES; i++) begin
            acc_q[i]                 <= clamp_c[i];
            acc_out[i*ACC_W +: ACC_W] <= clamp_c[i];
            sat_run[i]               <= sat_run[i] | ovf_c[i];
            sat[i]                   <= sat_run[i] | ovf_c[i];
          end
        end else if (win_last) begin
          for (int i = 0; i < LANES; i++) begin
            acc_out[i*ACC_W +: ACC_W] <= clamp_c[i];
            sat[i]                   <= sat_run[i] | ovf_c[i];
            acc_q[i]                 <= '0;
          end
          sat_run   <= '0;
          cnt_q     <= '0;
          acc_valid <= 1'b1;
        end else begin
          for (int i = 0; i < LANES; i++) begin
            acc_q[i]   <= clamp_c[i];
            sat_run[i] <= sat_run[i] | ovf_c[i];
          end
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_array_pipe.sv
// Bench for mac_array_pipe: three configurations share one stimulus stream and
// are checked against directed vectors and an integer reference model.
module tb_mac_array_pipe;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid;
  logic [31:0] a, b;
  logic [7:0]  len;

  logic [95:0] acc_out0;
  logic [63:0] acc_out1, acc_out2;
  logic        acc_valid0, acc_valid1, acc_valid2;
  logic [3:0]  sat0, sat1, sat2;
  logic        busy0, busy1, busy2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // cfg0: unsigned 24-bit, cfg1: unsigned 16-bit, cfg2: signed 16-bit
  mac_array_pipe #(.LANES(4), .DATA_W(8), .ACC_W(24), .SIGNED(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .a(a), .b(b), .len(len),
    .acc_out(acc_out0), .acc_valid(acc_valid0), .sat(sat0), .busy(busy0));
  mac_array_pipe #(.LANES(4), .DATA_W(8), .ACC_W(16), .SIGNED(0), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .a(a), .b(b), .len(len),
    .acc_out(acc_out1), .acc_valid(acc_valid1), .sat(sat1), .busy(busy1));
  mac_array_pipe #(.LANES(4), .DATA_W(8), .ACC_W(16), .SIGNED(1), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .a(a), .b(b), .len(len),
    .acc_out(acc_out2), .acc_valid(acc_valid2), .sat(sat2), .busy(busy2));

  typedef struct {
    bit          clr;
    bit          iv;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  len;
    int          sel;
    longint      exp_out;
    bit          exp_vld;
    bit          exp_sat;
    bit          exp_busy;
  } vec_t;

  vec_t vt[$];

  // Reference model state: result of each window computed with plain integers.
  longint      m_acc  [3][4];
  longint      m_out  [3][4];
  bit          m_satr [3][4];
  bit          m_sat  [3][4];
  int          m_cnt  [3];
  int          m_wlen [3];
  bit          m_vld  [3];
  bit          m_pend;
  logic [31:0] m_pa, m_pb;

  function automatic longint lane_val(int c, logic [7:0] x);
    if (c == 2) return longint'($signed(x));
    return longint'(x);
  endfunction

  function automatic longint clampv(int c, longint s, output bit ov);
    longint hi, lo;
    int w;
    w = (c == 0) ? 24 : 16;
    if (c == 2) begin
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -(longint'(1) << (w - 1));
    end else begin
      hi = (longint'(1) << w) - 1;
      lo = 0;
    end
    ov = (s > hi) || (s < lo);
    return (s > hi) ? hi : ((s < lo) ? lo : s);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_cnt[c] = 0; m_wlen[c] = 0; m_vld[c] = 1'b0;
      for (int l = 0; l < 4; l++) begin
        m_acc[c][l] = 0; m_out[c][l] = 0; m_satr[c][l] = 1'b0; m_sat[c][l] = 1'b0;
      end
    end
    m_pend = 1'b0; m_pa = '0; m_pb = '0;
  endtask

  task automatic model_step();
    int     wl;
    bit     last, ov;
    longint p, s;
    if (clr) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 3; c++) m_vld[c] = 1'b0;
    if (m_pend) begin
      for (int c = 0; c < 3; c++) begin
        wl = (m_cnt[c] == 0) ? int'(len) : m_wlen[c];
        if (m_cnt[c] == 0) m_wlen[c] = int'(len);
        last = (wl != 0) && (m_cnt[c] == wl - 1);
        for (int l = 0; l < 4; l++) begin
          p = lane_val(c, m_pa[l*8 +: 8]) * lane_val(c, m_pb[l*8 +: 8]);
          s = clampv(c, m_acc[c][l] + p, ov);
          if (wl == 0) begin
            m_acc[c][l] = s; m_out[c][l] = s;
            m_satr[c][l] = m_satr[c][l] | ov; m_sat[c][l] = m_satr[c][l];
          end else if (last) begin
            m_out[c][l] = s; m_sat[c][l] = m_satr[c][l] | ov;
            m_acc[c][l] = 0; m_satr[c][l] = 1'b0;
          end else begin
            m_acc[c][l] = s; m_satr[c][l] = m_satr[c][l] | ov;
          end
        end
        if (wl != 0) begin
          if (last) begin m_vld[c] = 1'b1; m_cnt[c] = 0; end
          else m_cnt[c] = m_cnt[c] + 1;
        end
      end
    end
    m_pend = in_valid; m_pa = a; m_pb = b;
  endtask

  function automatic longint dut_lane(int c, int l);
    case (c)
      0:       return longint'(acc_out0[l*24 +: 24]);
      1:       return longint'(acc_out1[l*16 +: 16]);
      default: return longint'($signed(acc_out2[l*16 +: 16]));
    endcase
  endfunction

  function automatic bit get_vld(int c);
    case (c) 0: return acc_valid0; 1: return acc_valid1; default: return acc_valid2; endcase
  endfunction

  function automatic bit get_sat(int c, int l);
    case (c) 0: return sat0[l]; 1: return sat1[l]; default: return sat2[l]; endcase
  endfunction

  function automatic bit get_busy(int c);
    case (c) 0: return busy0; 1: return busy1; default: return busy2; endcase
  endfunction

  task automatic chk(input string nm, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic cmp_model(input string tag);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("%s cfg%0d acc_valid", tag, c), longint'(get_vld(c)), longint'(m_vld[c]));
      chk($sformatf("%s cfg%0d busy", tag, c), longint'(get_busy(c)),
          longint'(m_pend || (m_cnt[c] != 0)));
      for (int l = 0; l < 4; l++) begin
        chk($sformatf("%s cfg%0d lane%0d acc_out", tag, c, l), dut_lane(c, l), m_out[c][l]);
        chk($sformatf("%s cfg%0d lane%0d sat", tag, c, l), longint'(get_sat(c, l)),
            longint'(m_sat[c][l]));
      end
    end
  endtask

  task automatic step(input bit c, input bit v, input logic [31:0] aa, input logic [31:0] bb,
                      input logic [7:0] ll);
    clr = c; in_valid = v; a = aa; b = bb; len = ll;
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic void add(bit c, bit v, logic [31:0] aa, logic [31:0] bb, logic [7:0] ll,
                              int s, longint eo, bit ev, bit es, bit eb);
    vt.push_back('{c, v, aa, bb, ll, s, eo, ev, es, eb});
  endfunction

  function automatic logic [7:0] pick_len();
    case ($urandom_range(0, 5))
      0:       return 8'd0;
      1:       return 8'd1;
      2:       return 8'd2;
      3:       return 8'd3;
      4:       return 8'($urandom_range(4, 9));
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    logic [31:0] aa, bb;
    logic [7:0]  cur_len;
    longint      rst_exp [4];

    // Four 3*5 samples in a len-4 window
    add(0,1,3,5,4, 0, 0,0,0,1);
    add(0,1,3,5,4, 0, 0,0,0,1);
    add(0,1,3,5,4, 0, 0,0,0,1);
    add(0,1,3,5,4, 0, 0,0,0,1);
    add(0,0,0,0,4, 0, 60,1,0,0);
    add(0,0,0,0,4, 0, 60,0,0,0);
    // Unsigned 16-bit free-running saturation
    add(1,0,0,0,0, 1, 0,0,0,0);
    add(0,1,'hff,'hff,0, 1, 0,0,0,1);
    add(0,1,'hff,'hff,0, 1, 65025,0,0,1);
    add(0,1,'hff,'hff,0, 1, 65535,0,1,1);
    add(0,0,0,0,0, 1, 65535,0,1,0);
    add(0,0,0,0,0, 1, 65535,0,1,0);
    // Signed windows, then signed negative clamp
    add(1,0,0,0,2, 2, 0,0,0,0);
    add(0,1,'h80,'h7f,2, 2, 0,0,0,1);
    add(0,1,'hff,'h01,2, 2, 0,0,0,1);
    add(0,0,0,0,2, 2, -16257,1,0,0);
    add(0,1,'h80,'h7f,3, 2, -16257,0,0,1);
    add(0,1,'h80,'h7f,3, 2, -16257,0,0,1);
    add(0,1,'h80,'h7f,3, 2, -16257,0,0,1);
    add(0,0,0,0,3, 2, -32768,1,1,0);
    // Mid-window clr with a concurrent sample, then a clean window
    add(0,1,2,3,4, 0, 48768,0,0,1);
    add(0,1,2,3,4, 0, 48768,0,0,1);
    add(1,1,2,3,4, 0, 0,0,0,0);
    add(0,1,1,1,4, 0, 0,0,0,1);
    add(0,1,1,1,4, 0, 0,0,0,1);
    add(0,1,1,1,4, 0, 0,0,0,1);
    add(0,1,1,1,4, 0, 0,0,0,1);
    add(0,0,0,0,4, 0, 4,1,0,0);
    // len 3 latched across idle gaps, then a len 7 window ignoring later len changes
    add(0,1,1,1,3, 0, 4,0,0,1);
    add(0,0,0,0,3, 0, 4,0,0,1);
    add(0,0,0,0,7, 0, 4,0,0,1);
    add(0,1,1,1,7, 0, 4,0,0,1);
    add(0,1,1,1,7, 0, 4,0,0,1);
    add(0,0,0,0,7, 0, 3,1,0,0);
    add(0,1,1,2,7, 0, 3,0,0,1);
    add(0,1,1,2,7, 0, 3,0,0,1);
    add(0,1,1,2,2, 0, 3,0,0,1);
    add(0,1,1,2,2, 0, 3,0,0,1);
    add(0,1,1,2,2, 0, 3,0,0,1);
    add(0,1,1,2,2, 0, 3,0,0,1);
    add(0,1,1,2,2, 0, 3,0,0,1);
    add(0,0,0,0,2, 0, 14,1,0,0);

    rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; a = '0; b = '0; len = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #11;
    cmp_model("reset");
    rst_n = 1'b1;

    foreach (vt[i]) begin
      step(vt[i].clr, vt[i].iv, vt[i].a, vt[i].b, vt[i].len);
      chk($sformatf("vec%0d acc_out", i), dut_lane(vt[i].sel, 0), vt[i].exp_out);
      chk($sformatf("vec%0d acc_valid", i), longint'(get_vld(vt[i].sel)), longint'(vt[i].exp_vld));
      chk($sformatf("vec%0d sat", i), longint'(get_sat(vt[i].sel, 0)), longint'(vt[i].exp_sat));
      chk($sformatf("vec%0d busy", i), longint'(get_busy(vt[i].sel)), longint'(vt[i].exp_busy));
    end

    // Async reset in the middle of a window, then four independent lanes
    step(0, 1, 32'h281e140a, 32'h07060504, 8'd3);
    step(0, 1, 32'h281e140a, 32'h07060504, 8'd3);
    chk("pre-reset busy", longint'(busy0), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    cmp_model("async reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 1, 32'h281e140a, 32'h07060504, 8'd3);
    step(0, 0, 32'h0, 32'h0, 8'd3);
    rst_exp = '{120, 300, 540, 840};
    chk("post-reset acc_valid", longint'(acc_valid0), 1);
    for (int l = 0; l < 4; l++)
      chk($sformatf("post-reset lane%0d acc_out", l), dut_lane(0, l), rst_exp[l]);
    cmp_model("post-reset");

    // Random mixed windows, clears and gaps
    cur_len = 8'd3;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) cur_len = pick_len();
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom, $urandom, cur_len);
      cmp_model($sformatf("rndA%0d", i));
    end

    // Long free-running run with large operands to drive every lane into saturation
    step(1, 0, 32'h0, 32'h0, 8'd0);
    for (int i = 0; i < 500; i++) begin
      for (int l = 0; l < 4; l++) begin
        aa[l*8 +: 8] = 8'($urandom_range(200, 255));
        bb[l*8 +: 8] = 8'($urandom_range(200, 255));
      end
      step(0, $urandom_range(0, 9) != 0, aa, bb, 8'd0);
      cmp_model($sformatf("rndB%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
